vmicro16_apb_arbiter: RTL and testbench



---
 rtl/vmicro16_apb_arbiter.sv | 159 +++++++++++++++
 tb/tb_vmicro16_apb_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter that serialises per-core APB masters onto one shared
// peripheral bus, with one-hot slave decode, unmapped completion and a watchdog.
module vmicro16_apb_arbiter #(
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 8,
  parameter int BUS_WIDTH    = 16,
  parameter int DEC_LSB      = 12,
  parameter int DEC_BITS     = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR,
  input  logic [MASTER_PORTS-1:0]           S_PWRITE,
  input  logic [MASTER_PORTS-1:0]           S_PSELx,
  input  logic [MASTER_PORTS-1:0]           S_PENABLE,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]           S_PREADY,
  output logic [BUS_WIDTH-1:0]              M_PADDR,
  output logic                              M_PWRITE,
  output logic [SLAVE_PORTS-1:0]            M_PSELx,
  output logic                              M_PENABLE,
  output logic [BUS_WIDTH-1:0]              M_PWDATA,
  input  logic [BUS_WIDTH-1:0]              M_PRDATA,
  input  logic                              M_PREADY,
  output logic [MASTER_PORTS-1:0]           grant,
  output logic                              timeout_err
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
  localparam int PW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic          mapped;
  logic [TW-1:0] timer;

  logic                    found;
  int                      j;
  logic [MASTER_PORTS-1:0] win_oh;
  logic [PW-1:0]           win_idx;
  logic [BUS_WIDTH-1:0]    win_addr, win_wdata;
  logic                    win_write;
  logic [DEC_BITS-1:0]     win_slv;
  logic                    win_mapped;
  logic [SLAVE_PORTS-1:0]  win_sel;
  logic                    timer_done;

  // Master-side PENABLE carries no arbitration meaning; requests are PSEL only.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  // Scan from the master after the last owner so every requester is reached
  // within MASTER_PORTS grants.
  always_comb begin
    found   = 1'b0;
    j       = 0;
    win_oh  = '0;
    win_idx = '0;
    for (int k = 1; k <= MASTER_PORTS; k++) begin
      j = (int'(ptr) + k) % MASTER_PORTS;
      if (!found && S_PSELx[j]) begin
        found      = 1'b1;
        win_oh[j]  = 1'b1;
        win_idx    = j[PW-1:0];
      end
    end
    win_addr  = '0;
    win_wdata = '0;
    win_write = 1'b0;
    for (int i = 0; i < MASTER_PORTS; i++) begin
      if (win_oh[i]) begin
        win_addr  = win_addr  | S_PADDR[BUS_WIDTH*i +: BUS_WIDTH];
        win_wdata = win_wdata | S_PWDATA[BUS_WIDTH*i +: BUS_WIDTH];
        win_write = win_write | S_PWRITE[i];
      end
    end
    win_slv    = win_addr[DEC_LSB +: DEC_BITS];
    win_mapped = (int'(win_slv) < SLAVE_PORTS);
    for (int s = 0; s < SLAVE_PORTS; s++)
      win_sel[s] = win_mapped && (int'(win_slv) == s);
  end

  assign timer_done = (TIMEOUT != 0) && (int'(timer) + 1 >= TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      ptr         <= PW'(MASTER_PORTS - 1);
      mapped      <= 1'b0;
      timer       <= '0;
      grant       <= '0;
      S_PRDATA    <= '0;
      S_PREADY    <= '0;
      M_PADDR     <= '0;
      M_PWRITE    <= 1'b0;
      M_PSELx     <= '0;
      M_PENABLE   <= 1'b0;
      M_PWDATA    <= '0;
      timeout_err <= 1'b0;
    end else begin
      S_PREADY    <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: if (found) begin
          M_PADDR  <= win_addr;
          M_PWRITE <= win_write;
          M_PWDATA <= win_wdata;
          M_PSELx  <= win_sel;
          mapped   <= win_mapped;
          grant    <= win_oh;
          ptr      <= win_idx;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          timer <= '0;
          if (mapped) begin
            M_PENABLE <= 1'b1;
            state     <= ST_ACCESS;
          end else begin
            for (int i = 0; i < MASTER_PORTS; i++)
              if (grant[i]) S_PRDATA[BUS_WIDTH*i +: BUS_WIDTH] <= '0;
            S_PREADY <= grant;
            state    <= ST_RESP;
          end
        end
        ST_ACCESS: begin
          if (M_PREADY) begin
            for (int i = 0; i < MASTER_PORTS; i++)
              if (grant[i]) S_PRDATA[BUS_WIDTH*i +: BUS_WIDTH] <= M_PRDATA;
            M_PSELx   <= '0;
            M_PENABLE <= 1'b0;
            S_PREADY  <= grant;
            state     <= ST_RESP;
          end else if (timer_done) begin
            for (int i = 0; i < MASTER_PORTS; i++)
              if (grant[i]) S_PRDATA[BUS_WIDTH*i +: BUS_WIDTH] <= '0;
            M_PSELx     <= '0;
            M_PENABLE   <= 1'b0;
            S_PREADY    <= grant;
            timeout_err <= 1'b1;
            state       <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          grant <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vmicro16_apb_arbiter.sv
// Bench for vmicro16_apb_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level round-robin model.
module tb_vmicro16_apb_arbiter;
  localparam int MP = 4, SP = 8, BW = 16, TMO = 8;

  logic clk = 1'b0, reset = 1'b0;
  logic [MP*BW-1:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic [MP-1:0]    S_PWRITE, S_PSELx, S_PENABLE, S_PREADY, grant;
  logic [BW-1:0]    M_PADDR, M_PWDATA, M_PRDATA;
  logic [SP-1:0]    M_PSELx;
  logic             M_PWRITE, M_PENABLE, M_PREADY, timeout_err;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  vmicro16_apb_arbiter #(.MASTER_PORTS(MP), .SLAVE_PORTS(SP), .BUS_WIDTH(BW),
    .DEC_LSB(12), .DEC_BITS(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
    .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA),
    .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .M_PADDR(M_PADDR),
    .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY),
    .grant(grant), .timeout_err(timeout_err));

  // Slave: wait states = PADDR[1:0], never ready when PADDR[3:0]==F.
  int acc_cnt = 0;
  logic fixed_en = 1'b0;
  logic [BW-1:0] fixed_val = '0;
  wire acc = (|M_PSELx) && M_PENABLE;
  assign M_PREADY = acc && (M_PADDR[3:0] != 4'hF) && (acc_cnt >= int'(M_PADDR[1:0]));
  assign M_PRDATA = fixed_en ? fixed_val : (M_PADDR ^ 16'h5A5A);
  always @(posedge clk) acc_cnt <= (acc && !M_PREADY) ? acc_cnt + 1 : 0;

  // Per-round transactions, observations and model expectations.
  logic [BW-1:0] t_addr [MP];
  logic [BW-1:0] t_wd   [MP];
  logic          t_wr   [MP];
  int o_n, o_terr, o_nw, o_multi;
  bit o_hung;
  int o_m [0:15], o_cyc [0:15];
  logic [MP*BW-1:0] o_sl [0:15];
  logic [MP-1:0] o_gnt [0:15];
  logic [SP-1:0] o_sel [0:15];
  logic [BW-1:0] o_waddr [0:15], o_wdata [0:15];
  logic [SP-1:0] tr_sel [0:63];
  logic tr_en [0:63], tr_terr [0:63];

  int mptr = MP - 1;
  logic [MP*BW-1:0] m_slices = '0;
  int e_n, e_terr, e_nw;
  int e_m [0:15], e_cyc [0:15];
  logic [MP*BW-1:0] e_sl [0:15];
  logic [SP-1:0] e_sel [0:15];
  logic [BW-1:0] e_waddr [0:15], e_wdata [0:15];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; S_PSELx = '0; S_PENABLE = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mptr = MP - 1; m_slices = '0;
  endtask

  // Model: serve pending masters in round-robin order from the last owner.
  // A transfer seen at cycle t completes at t+lat; the next starts at t+lat+1.
  task automatic model_round(input logic [MP-1:0] mask, input bit keep, input int n_target);
    logic [MP-1:0] pend; int t, m, idx, lat, jj;
    logic [BW-1:0] data; logic [SP-1:0] sel;
    pend = mask; t = 0; e_n = 0; e_terr = 0; e_nw = 0;
    while (pend != '0 && e_n < n_target) begin
      m = -1;
      for (int k = 1; k <= MP; k++) begin
        jj = (mptr + k) % MP;
        if (m < 0 && ((pend >> jj) & 1) != 0) m = jj;
      end
      idx = int'(t_addr[m][15:12]);
      sel = '0; data = '0;
      if (idx >= SP) lat = 2;
      else begin
        sel = SP'(1) << idx;
        if (t_addr[m][3:0] == 4'hF) begin lat = 2 + TMO; e_terr++; end
        else begin
          lat  = 3 + int'(t_addr[m][1:0]);
          data = fixed_en ? fixed_val : (t_addr[m] ^ 16'h5A5A);
          if (t_wr[m]) begin e_waddr[e_nw] = t_addr[m]; e_wdata[e_nw] = t_wd[m]; e_nw++; end
        end
      end
      m_slices[m*BW +: BW] = data;
      e_m[e_n] = m; e_cyc[e_n] = t + lat; e_sel[e_n] = sel; e_sl[e_n] = m_slices; e_n++;
      t = t + lat + 1; mptr = m;
      if (!keep) pend = pend & ~(MP'(1) << m);
    end
  endtask

  // Drives one round of requests and records what happens; no checking here.
  task automatic run_round(input logic [MP-1:0] mask, input bit keep, input int n_target);
    int cyc, m; logic [MP-1:0] pend; logic [SP-1:0] last_sel;
    o_n = 0; o_terr = 0; o_nw = 0; o_multi = 0; o_hung = 0; last_sel = '0; cyc = 0;
    for (int c = 0; c < 64; c++) begin tr_sel[c] = '0; tr_en[c] = 1'b0; tr_terr[c] = 1'b0; end
    @(negedge clk);
    for (int i = 0; i < MP; i++) begin
      S_PADDR[i*BW +: BW] = t_addr[i]; S_PWDATA[i*BW +: BW] = t_wd[i]; S_PWRITE[i] = t_wr[i];
    end
    S_PSELx = mask; S_PENABLE = mask; pend = mask;
    while (pend != '0 && o_n < n_target) begin
      @(negedge clk); cyc++;
      if (cyc > 300) begin o_hung = 1; break; end
      if (cyc < 64) begin tr_sel[cyc] = M_PSELx; tr_en[cyc] = M_PENABLE; tr_terr[cyc] = timeout_err; end
      if (timeout_err) o_terr++;
      if (acc) last_sel = M_PSELx;
      if (M_PREADY && M_PWRITE && o_nw < 16) begin
        o_waddr[o_nw] = M_PADDR; o_wdata[o_nw] = M_PWDATA; o_nw++;
      end
      if (S_PREADY != '0) begin
        if ($countones(S_PREADY) != 1) o_multi++;
        m = 0;
        for (int i = MP - 1; i >= 0; i--) if (S_PREADY[i]) m = i;
        o_m[o_n] = m; o_cyc[o_n] = cyc; o_sl[o_n] = S_PRDATA; o_gnt[o_n] = grant;
        o_sel[o_n] = last_sel; last_sel = '0; o_n++;
        if (!keep) begin pend[m] = 1'b0; S_PSELx[m] = 1'b0; S_PENABLE[m] = 1'b0; end
      end
    end
    S_PSELx = '0; S_PENABLE = '0;
    @(negedge clk); cyc++;
    if (S_PREADY != '0) o_multi++;
    if (timeout_err) o_terr++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({grant, S_PREADY, M_PSELx, M_PENABLE, timeout_err} !== '0) begin n_bad++;
      $display("FAIL reset_ctrl: got grant=%h rdy=%h sel=%h en=%b terr=%b exp all 0",
               grant, S_PREADY, M_PSELx, M_PENABLE, timeout_err); end
    n_cmp++; if ({M_PADDR, M_PWDATA, M_PWRITE} !== '0) begin n_bad++;
      $display("FAIL reset_mbus: got addr=%h wd=%h wr=%b exp 0", M_PADDR, M_PWDATA, M_PWRITE); end
    n_cmp++; if (S_PRDATA !== '0) begin n_bad++;
      $display("FAIL reset_prdata: got %h exp 0", S_PRDATA); end
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    t_addr[1] = 16'h2004; t_wd[1] = 16'h1234; t_wr[1] = 1'b1;
    run_round(4'b0010, 0, 1);
    n_cmp++; if (o_n !== 1 || o_m[0] !== 1) begin n_bad++;
      $display("FAIL wr_master: got n=%0d m=%0d exp n=1 m=1", o_n, o_m[0]); end
    n_cmp++; if (o_cyc[0] !== 3) begin n_bad++;
      $display("FAIL wr_latency: got %0d exp 3", o_cyc[0]); end
    n_cmp++; if (tr_sel[1] !== 8'h04 || tr_en[1] !== 1'b0) begin n_bad++;
      $display("FAIL wr_setup: got sel=%h en=%b exp sel=04 en=0", tr_sel[1], tr_en[1]); end
    n_cmp++; if (tr_sel[2] !== 8'h04 || tr_en[2] !== 1'b1) begin n_bad++;
      $display("FAIL wr_access: got sel=%h en=%b exp sel=04 en=1", tr_sel[2], tr_en[2]); end
    n_cmp++; if (o_nw !== 1 || o_waddr[0] !== 16'h2004 || o_wdata[0] !== 16'h1234) begin n_bad++;
      $display("FAIL wr_slave: got n=%0d addr=%h data=%h exp 1 2004 1234", o_nw, o_waddr[0], o_wdata[0]); end
    n_cmp++; if (o_gnt[0] !== 4'b0010) begin n_bad++;
      $display("FAIL wr_grant: got %b exp 0010", o_gnt[0]); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    fixed_en = 1'b1; fixed_val = 16'hBEEF;
    t_addr[0] = 16'h3000; t_addr[2] = 16'h3000; t_wr[0] = 1'b0; t_wr[2] = 1'b0;
    run_round(4'b0101, 0, 2);
    fixed_en = 1'b0;
    n_cmp++; if (o_n !== 2 || o_m[0] !== 0 || o_m[1] !== 2) begin n_bad++;
      $display("FAIL rr_order: got n=%0d %0d,%0d exp 0,2", o_n, o_m[0], o_m[1]); end
    n_cmp++; if (o_cyc[0] !== 3 || o_cyc[1] !== 7) begin n_bad++;
      $display("FAIL rr_timing: got %0d,%0d exp 3,7", o_cyc[0], o_cyc[1]); end
    n_cmp++; if (o_sl[0][0 +: 16] !== 16'hBEEF || o_sl[0][32 +: 16] !== 16'h0000) begin n_bad++;
      $display("FAIL rr_first_data: got s0=%h s2=%h exp BEEF 0000", o_sl[0][0 +: 16], o_sl[0][32 +: 16]); end
    n_cmp++; if (o_sl[1][0 +: 16] !== 16'hBEEF || o_sl[1][32 +: 16] !== 16'hBEEF) begin n_bad++;
      $display("FAIL rr_second_data: got s0=%h s2=%h exp BEEF BEEF", o_sl[1][0 +: 16], o_sl[1][32 +: 16]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < MP; i++) begin t_addr[i] = 16'(16'h1000 * (i + 1)); t_wr[i] = 1'b0; end
    run_round(4'hF, 1, 6);
    n_cmp++; if (o_n !== 6) begin n_bad++; $display("FAIL b2b_count: got %0d exp 6", o_n); end
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if (o_m[k] !== k % MP || o_cyc[k] !== 3 + 4 * k) begin n_bad++;
        $display("FAIL b2b_grant%0d: got m=%0d cyc=%0d exp m=%0d cyc=%0d", k, o_m[k], o_cyc[k], k % MP, 3 + 4 * k); end
    end
  endtask

  task automatic test_unmapped();
    t_addr[3] = 16'h1000; t_wr[3] = 1'b0;
    run_round(4'b1000, 0, 1);
    n_cmp++; if (o_sl[0][48 +: 16] !== 16'h4A5A) begin n_bad++;
      $display("FAIL unm_preload: got %h exp 4A5A", o_sl[0][48 +: 16]); end
    t_addr[3] = 16'hF000;
    run_round(4'b1000, 0, 1);
    n_cmp++; if (o_n !== 1 || o_m[0] !== 3 || o_cyc[0] !== 2) begin n_bad++;
      $display("FAIL unm_latency: got n=%0d m=%0d cyc=%0d exp 1 3 2", o_n, o_m[0], o_cyc[0]); end
    n_cmp++; if (o_sl[0][48 +: 16] !== 16'h0000) begin n_bad++;
      $display("FAIL unm_data: got %h exp 0000", o_sl[0][48 +: 16]); end
    n_cmp++; if (tr_sel[1] !== '0 || tr_sel[2] !== '0 || tr_en[2] !== 1'b0) begin n_bad++;
      $display("FAIL unm_select: got sel1=%h sel2=%h en2=%b exp 0", tr_sel[1], tr_sel[2], tr_en[2]); end
  endtask

  task automatic test_timeout();
    do_reset();
    t_addr[1] = 16'h1000; t_addr[3] = 16'h3000; t_wr[1] = 1'b0; t_wr[3] = 1'b0; t_wr[2] = 1'b0;
    run_round(4'b1010, 0, 2);
    n_cmp++; if (o_sl[1][16 +: 16] !== 16'h4A5A) begin n_bad++;
      $display("FAIL tmo_preload: got %h exp 4A5A", o_sl[1][16 +: 16]); end
    t_addr[1] = 16'h100F; t_addr[2] = 16'h2000;
    run_round(4'b0110, 0, 2);
    n_cmp++; if (o_n !== 2 || o_m[0] !== 1 || o_cyc[0] !== 2 + TMO) begin n_bad++;
      $display("FAIL tmo_abort: got n=%0d m=%0d cyc=%0d exp 2 1 %0d", o_n, o_m[0], o_cyc[0], 2 + TMO); end
    n_cmp++; if (tr_sel[1 + TMO] !== 8'h02 || tr_en[1 + TMO] !== 1'b1 || tr_sel[2 + TMO] !== '0) begin n_bad++;
      $display("FAIL tmo_drop: got last_sel=%h en=%b next_sel=%h exp 02 1 00",
               tr_sel[1 + TMO], tr_en[1 + TMO], tr_sel[2 + TMO]); end
    n_cmp++; if (o_terr !== 1 || tr_terr[2 + TMO] !== 1'b1) begin n_bad++;
      $display("FAIL tmo_err: got pulses=%0d at_resp=%b exp 1 1", o_terr, tr_terr[2 + TMO]); end
    n_cmp++; if (o_sl[0][16 +: 16] !== 16'h0000) begin n_bad++;
      $display("FAIL tmo_data: got %h exp 0000", o_sl[0][16 +: 16]); end
    n_cmp++; if (o_m[1] !== 2 || o_cyc[1] !== 6 + TMO || o_sl[1][32 +: 16] !== 16'h7A5A) begin n_bad++;
      $display("FAIL tmo_next: got m=%0d cyc=%0d d=%h exp 2 %0d 7A5A", o_m[1], o_cyc[1], o_sl[1][32 +: 16], 6 + TMO); end
  endtask

  task automatic test_reset_mid();
    int w; bit seen;
    w = 0; seen = 0;
    @(negedge clk);
    S_PADDR[0 +: BW] = 16'h100F; S_PWRITE = '0; S_PSELx = 4'b0001; S_PENABLE = 4'b0001;
    while (!M_PENABLE && w < 20) begin @(negedge clk); w++; end
    n_cmp++; if (M_PENABLE !== 1'b1) begin n_bad++;
      $display("FAIL mid_access: got en=%b exp 1", M_PENABLE); end
    @(negedge clk);
    S_PADDR[2*BW +: BW] = 16'h2000; S_PSELx = 4'b0101;
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({grant, M_PSELx, M_PENABLE, S_PREADY, timeout_err} !== '0) begin n_bad++;
      $display("FAIL mid_async: got grant=%h sel=%h en=%b rdy=%h exp 0", grant, M_PSELx, M_PENABLE, S_PREADY); end
    n_cmp++; if ({M_PADDR, S_PRDATA} !== '0) begin n_bad++;
      $display("FAIL mid_data: got addr=%h prdata=%h exp 0", M_PADDR, S_PRDATA); end
    repeat (2) begin @(negedge clk); if (S_PREADY !== '0) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_no_ready: got 1 exp 0"); end
    S_PSELx = '0; S_PENABLE = '0; reset = 1'b1;
    t_addr[0] = 16'h1000; t_addr[2] = 16'h2000; t_wr[0] = 1'b0; t_wr[2] = 1'b0;
    run_round(4'b0101, 0, 2);
    n_cmp++; if (o_n !== 2 || o_m[0] !== 0 || o_m[1] !== 2) begin n_bad++;
      $display("FAIL mid_first_grant: got n=%0d %0d,%0d exp 0,2", o_n, o_m[0], o_m[1]); end
  endtask

  task automatic test_random();
    logic [MP-1:0] mask; int idx;
    do_reset();
    for (int r = 0; r < 25; r++) begin
      mask = MP'($urandom_range(1, (1 << MP) - 1));
      for (int i = 0; i < MP; i++) begin
        idx = ($urandom_range(0, 9) < 8) ? $urandom_range(0, SP - 1) : $urandom_range(SP, 15);
        t_addr[i] = {4'(idx), 12'($urandom)};
        t_wd[i] = 16'($urandom); t_wr[i] = 1'($urandom);
      end
      model_round(mask, 0, MP);
      run_round(mask, 0, MP);
      n_cmp++; if (o_hung !== 1'b0 || o_n !== e_n || o_multi !== 0) begin n_bad++;
        $display("FAIL rnd%0d_count: got n=%0d hung=%b multi=%0d exp n=%0d", r, o_n, o_hung, o_multi, e_n); end
      for (int k = 0; k < e_n && k < o_n; k++) begin
        n_cmp++; if (o_m[k] !== e_m[k] || o_cyc[k] !== e_cyc[k] || o_gnt[k] !== MP'(1) << e_m[k]) begin n_bad++;
          $display("FAIL rnd%0d_xfer%0d: got m=%0d cyc=%0d g=%b exp m=%0d cyc=%0d", r, k, o_m[k], o_cyc[k], o_gnt[k], e_m[k], e_cyc[k]); end
        n_cmp++; if (o_sl[k] !== e_sl[k] || o_sel[k] !== e_sel[k]) begin n_bad++;
          $display("FAIL rnd%0d_data%0d: got sl=%h sel=%h exp sl=%h sel=%h", r, k, o_sl[k], o_sel[k], e_sl[k], e_sel[k]); end
      end
      n_cmp++; if (o_terr !== e_terr || o_nw !== e_nw) begin n_bad++;
        $display("FAIL rnd%0d_side: got terr=%0d wr=%0d exp terr=%0d wr=%0d", r, o_terr, o_nw, e_terr, e_nw); end
      for (int w = 0; w < e_nw && w < o_nw; w++) begin
        n_cmp++; if (o_waddr[w] !== e_waddr[w] || o_wdata[w] !== e_wdata[w]) begin n_bad++;
          $display("FAIL rnd%0d_write%0d: got %h/%h exp %h/%h", r, w, o_waddr[w], o_wdata[w], e_waddr[w], e_wdata[w]); end
      end
    end
  endtask

  initial begin
    S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
    for (int i = 0; i < MP; i++) begin t_addr[i] = '0; t_wd[i] = '0; t_wr[i] = 1'b0; end
    test_reset();
    test_single_write();
    test_same_cycle();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
